page_table_walker: RTL and testbench

- Services TLB misses by walking a two-level in-memory page table; sits directly downstream of the TLB fault output and feeds the TLB refill inputs.
- On a fault it reads the L1 and optionally the L2 page-table entry (PTE) over a req/ack memory port.
- It then returns the physical page address with a one-cycle fill pulse, or reports an error.
- Single outstanding walk; no internal caching.

---
 rtl/page_table_walker_pkg.sv | 31 +++
 rtl/ptw_timeout_counter.sv | 31 +++
 rtl/page_table_walker.sv | 149 ++++++++++++++
 tb/tb_page_table_walker.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/page_table_walker_pkg.sv
// Shared constants and types for the two-level page table walker.
// Slice positions are derived from the machine word width and the page size.
package page_table_walker_pkg;

    localparam int BIT_COUNT     = 32;
    localparam int PAGE_SIZE     = 4096;
    localparam int PAGE_OFFSET_W = $clog2(PAGE_SIZE);
    localparam int VPN_W         = (BIT_COUNT - PAGE_OFFSET_W) / 2;
    localparam int VPN0_LSB      = PAGE_OFFSET_W;
    localparam int VPN1_LSB      = PAGE_OFFSET_W + VPN_W;

    localparam int PTE_V_BIT = 0;
    localparam int PTE_L_BIT = 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        L1_REQ = 3'd1,
        L2_REQ = 3'd2,
        DONE   = 3'd3,
        ERR    = 3'd4,
        COOL   = 3'd5
    } ptw_state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_INV_L1  = 2'b01,
        ERR_INV_L2  = 2'b10,
        ERR_TIMEOUT = 2'b11
    } ptw_err_t;

endpackage

// File: rtl/ptw_timeout_counter.sv
// Wait-cycle counter for one outstanding memory read; expired flags the cycle
// in which the count would reach TIMEOUT.
module ptw_timeout_counter #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] count;

    // NOTE: sequential state is written with <= so every register samples the
    // pre-edge values of its inputs, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired = enable && (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/page_table_walker.sv
// Two-level page table walker: services one TLB miss at a time over a
// req/ack memory port and returns either a fill pulse or an error pulse.
module page_table_walker
    import page_table_walker_pkg::*;
#(
    parameter int ADDR_W   = BIT_COUNT,
    parameter int OFFSET_W = VPN0_LSB,
    parameter int VPN1_W   = BIT_COUNT - VPN1_LSB,
    parameter int VPN0_W   = VPN1_LSB - VPN0_LSB,
    parameter int TIMEOUT  = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              walk_req,
    input  logic [ADDR_W-1:0] walk_vaddr,
    input  logic [ADDR_W-1:0] ptbr,
    output logic              walk_busy,
    output logic              fill_valid,
    output logic [ADDR_W-1:0] fill_paddr,
    output logic              walk_error,
    output logic [1:0]        error_code,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [ADDR_W-1:0] mem_rdata
);

    ptw_state_t        state, state_nxt;
    ptw_err_t          err_q, err_nxt;
    logic [VPN0_W-1:0] vpn0_q, vpn0_nxt;
    logic              mem_req_nxt;
    logic [ADDR_W-1:0] mem_addr_nxt;
    logic [ADDR_W-1:0] fill_paddr_nxt;

    logic in_req;
    logic pte_v;
    logic pte_l;
    logic cnt_clear;
    logic cnt_enable;
    logic cnt_expired;
    logic unused_bits;

    assign in_req     = (state == L1_REQ) || (state == L2_REQ);
    assign pte_v      = mem_rdata[PTE_V_BIT];
    assign pte_l      = mem_rdata[PTE_L_BIT];
    assign cnt_clear  = !in_req || mem_ack;
    assign cnt_enable = in_req && !mem_ack;

    ptw_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (cnt_clear),
        .enable  (cnt_enable),
        .expired (cnt_expired)
    );

    always_comb begin
        // NOTE: every variable gets a default before the case so no path can
        // leave one unassigned, which would otherwise infer a latch.
        state_nxt      = state;
        err_nxt        = err_q;
        vpn0_nxt       = vpn0_q;
        mem_req_nxt    = mem_req;
        mem_addr_nxt   = mem_addr;
        fill_paddr_nxt = fill_paddr;

        case (state)
            IDLE: begin
                if (walk_req) begin
                    vpn0_nxt     = walk_vaddr[OFFSET_W +: VPN0_W];
                    err_nxt      = ERR_NONE;
                    mem_req_nxt  = 1'b1;
                    mem_addr_nxt = {ptbr[ADDR_W-1:OFFSET_W], walk_vaddr[ADDR_W-1 -: VPN1_W], 2'b00};
                    state_nxt    = L1_REQ;
                end
            end
            L1_REQ: begin
                // An ack always beats an expiring counter in the same cycle.
                if (mem_ack) begin
                    if (!pte_v) begin
                        mem_req_nxt = 1'b0;
                        err_nxt     = ERR_INV_L1;
                        state_nxt   = ERR;
                    end else if (pte_l) begin
                        mem_req_nxt    = 1'b0;
                        fill_paddr_nxt = {mem_rdata[ADDR_W-1 -: VPN1_W], vpn0_q, {OFFSET_W{1'b0}}};
                        state_nxt      = DONE;
                    end else begin
                        mem_addr_nxt = {mem_rdata[ADDR_W-1:OFFSET_W], vpn0_q, 2'b00};
                        state_nxt    = L2_REQ;
                    end
                end else if (cnt_expired) begin
                    mem_req_nxt = 1'b0;
                    err_nxt     = ERR_TIMEOUT;
                    state_nxt   = ERR;
                end
            end
            L2_REQ: begin
                if (mem_ack) begin
                    mem_req_nxt = 1'b0;
                    if (!pte_v) begin
                        err_nxt   = ERR_INV_L2;
                        state_nxt = ERR;
                    end else begin
                        fill_paddr_nxt = {mem_rdata[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
                        state_nxt      = DONE;
                    end
                end else if (cnt_expired) begin
                    mem_req_nxt = 1'b0;
                    err_nxt     = ERR_TIMEOUT;
                    state_nxt   = ERR;
                end
            end
            DONE:    state_nxt = COOL;
            ERR:     state_nxt = COOL;
            COOL:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            err_q      <= ERR_NONE;
            vpn0_q     <= '0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            fill_paddr <= '0;
        end else begin
            state      <= state_nxt;
            err_q      <= err_nxt;
            vpn0_q     <= vpn0_nxt;
            mem_req    <= mem_req_nxt;
            mem_addr   <= mem_addr_nxt;
            fill_paddr <= fill_paddr_nxt;
        end
    end

    // COOL is deliberately excluded so a held fault level sees the walker idle.
    assign walk_busy  = in_req || (state == DONE) || (state == ERR);
    assign fill_valid = (state == DONE);
    assign walk_error = (state == ERR);
    assign error_code = err_q;

    assign unused_bits = &{1'b0, walk_vaddr[OFFSET_W-1:0], ptbr[OFFSET_W-1:0], mem_rdata[OFFSET_W-1:2]};

endmodule

// File: tb/tb_page_table_walker.sv
// Self-checking bench for page_table_walker: directed corner cases plus
// randomized walks compared against an arithmetic page-table model.
module tb_page_table_walker;

    localparam int TIMEOUT = 255;
    localparam int MAX_CYC = 700;

    logic        clk = 1'b0;
    logic        rst;
    logic        walk_req;
    logic [31:0] walk_vaddr;
    logic [31:0] ptbr;
    logic        walk_busy;
    logic        fill_valid;
    logic [31:0] fill_paddr;
    logic        walk_error;
    logic [1:0]  error_code;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem [logic [31:0]];

    typedef struct {
        int          n_reads;
        logic [31:0] a0;
        logic [31:0] a1;
        bit          fill;
        logic [31:0] paddr;
        logic [1:0]  code;
        int          lat;
        int          req_cycles;
    } walk_exp_t;

    page_table_walker #(.TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .walk_req   (walk_req),
        .walk_vaddr (walk_vaddr),
        .ptbr       (ptbr),
        .walk_busy  (walk_busy),
        .fill_valid (fill_valid),
        .fill_paddr (fill_paddr),
        .walk_error (walk_error),
        .error_code (error_code),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    // Reference: table lookups by plain address arithmetic on the memory image.
    function automatic walk_exp_t model_walk(input logic [31:0] vaddr, input logic [31:0] pt,
                                             input int d1, input int d2);
        walk_exp_t   e;
        logic [31:0] pte1;
        logic [31:0] pte2;
        e = '{default: 0};
        e.n_reads = 1;
        e.a0 = (pt & 32'hFFFF_F000) + ((vaddr >> 22) << 2);
        if (d1 >= TIMEOUT) begin
            e.code = 2'b11;
            e.req_cycles = TIMEOUT;
            return e;
        end
        e.req_cycles = d1 + 1;
        pte1 = rd(e.a0);
        if (pte1[0] == 1'b0) begin
            e.code = 2'b01;
            return e;
        end
        if (pte1[1] == 1'b1) begin
            e.fill  = 1'b1;
            e.paddr = (pte1 & 32'hFFC0_0000) | (vaddr & 32'h003F_F000);
            e.lat   = 2 + d1;
            return e;
        end
        e.n_reads = 2;
        e.a1 = (pte1 & 32'hFFFF_F000) + (((vaddr >> 12) & 32'h3FF) << 2);
        if (d2 >= TIMEOUT) begin
            e.code = 2'b11;
            e.req_cycles += TIMEOUT;
            return e;
        end
        e.req_cycles += d2 + 1;
        pte2 = rd(e.a1);
        if (pte2[0] == 1'b0) begin
            e.code = 2'b10;
        end else begin
            e.fill  = 1'b1;
            e.paddr = pte2 & 32'hFFFF_F000;
            e.lat   = 3 + d1 + d2;
        end
        return e;
    endfunction

    // Drives one walk, acts as the memory (ack after d1/d2 wait cycles) and
    // compares what it saw with the model.
    task automatic do_walk(input string tag, input logic [31:0] vaddr, input logic [31:0] pt,
                           input int d1, input int d2, input bit hold, input bit late_ack,
                           input bit rst_mid);
        walk_exp_t   e;
        int          n_reads = 0, n_fill = 0, n_err = 0, req_cycles = 0, moved = 0;
        int          end_cyc = -1, fill_cyc = -1, wait_cnt = 0, dly = 0, idle_cnt = 0;
        logic [31:0] rd0 = '0, rd1 = '0, paddr_obs = '0, cur_addr = '0;
        logic        busy_cool = 1'b1, busy_idle = 1'b1;
        logic        seen_busy = 1'b0, req_prev = 1'b0, ack_prev = 1'b0, aborted = 1'b0;

        e = model_walk(vaddr, pt, d1, d2);
        @(negedge clk);
        walk_vaddr = vaddr;
        ptbr       = pt;
        walk_req   = 1'b1;
        mem_ack    = 1'b0;

        for (int cyc = 1; cyc <= MAX_CYC && idle_cnt < 4; cyc++) begin
            @(negedge clk);
            if (!hold || (end_cyc >= 0 && cyc >= end_cyc + 2)) walk_req = 1'b0;
            if (fill_valid) begin
                n_fill++;
                paddr_obs = fill_paddr;
                end_cyc = cyc;
                if (fill_cyc < 0) fill_cyc = cyc;
            end
            if (walk_error) begin
                n_err++;
                end_cyc = cyc;
            end
            if (end_cyc >= 0 && cyc == end_cyc + 1) busy_cool = walk_busy;
            if (end_cyc >= 0 && cyc == end_cyc + 2) busy_idle = walk_busy;

            if (mem_req) begin
                req_cycles++;
                if (!req_prev || ack_prev) begin
                    if (n_reads == 0) rd0 = mem_addr;
                    else if (n_reads == 1) rd1 = mem_addr;
                    n_reads++;
                    wait_cnt = 0;
                end else if (mem_addr != cur_addr) begin
                    moved++;
                end
                cur_addr = mem_addr;
                dly = (n_reads == 1) ? d1 : d2;
                if (wait_cnt == dly) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rd(mem_addr);
                end else begin
                    mem_ack   = 1'b0;
                    mem_rdata = $urandom;
                end
                wait_cnt++;
                if (rst_mid && n_reads == 2 && wait_cnt == 2) begin
                    #2 rst = 1'b0;
                    #1;
                    check({tag, "/rst_ctrl"}, {mem_req, walk_busy, fill_valid, walk_error, error_code}, 0);
                    check({tag, "/rst_data"}, {fill_paddr, mem_addr}, 0);
                    mem_ack = 1'b0;
                    aborted = 1'b1;
                    break;
                end
            end else begin
                mem_ack   = late_ack;
                mem_rdata = 32'h0000_0003;
            end
            ack_prev = mem_ack && mem_req;
            req_prev = mem_req;
            if (walk_busy) seen_busy = 1'b1;
            else if (seen_busy) idle_cnt++;
        end
        walk_req = 1'b0;
        mem_ack  = 1'b0;

        if (aborted) begin
            check({tag, "/rst_in_l2"}, n_reads, 2);
            @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            check({tag, "/rst_idle"}, {walk_busy, mem_req, fill_valid, walk_error, error_code}, 0);
            return;
        end

        check({tag, "/complete"}, idle_cnt >= 4, 1);
        check({tag, "/reads"}, n_reads, e.n_reads);
        check({tag, "/addr_l1"}, rd0, e.a0);
        if (e.n_reads > 1) check({tag, "/addr_l2"}, rd1, e.a1);
        check({tag, "/fills"}, n_fill, e.fill);
        check({tag, "/errors"}, n_err, !e.fill);
        check({tag, "/code"}, error_code, e.code);
        if (e.fill) begin
            check({tag, "/paddr"}, paddr_obs, e.paddr);
            check({tag, "/latency"}, fill_cyc, e.lat);
        end
        check({tag, "/req_cycles"}, req_cycles, e.req_cycles);
        check({tag, "/addr_stable"}, moved, 0);
        check({tag, "/busy_cool"}, busy_cool, 0);
        check({tag, "/busy_idle"}, busy_idle, 0);
    endtask

    initial begin
        logic [31:0] va, pt, l1a, l2a, t, junk;
        int          kind;

        rst        = 1'b0;
        walk_req   = 1'b0;
        walk_vaddr = '0;
        ptbr       = '0;
        mem_ack    = 1'b0;
        mem_rdata  = '0;
        repeat (3) @(negedge clk);
        check("reset/ctrl", {walk_busy, fill_valid, walk_error, error_code, mem_req}, 0);
        check("reset/data", {fill_paddr, mem_addr}, 0);
        rst = 1'b1;
        @(negedge clk);

        mem.delete();
        mem[32'h0001_0FFC] = 32'h0002_0001;
        mem[32'h0002_0FFC] = 32'h1000_0001;
        do_walk("two_level", 32'hFFFF_F00A, 32'h0001_0000, 0, 0, 0, 0, 0);

        mem.delete();
        mem[32'h0001_0010] = 32'h4040_0003;
        do_walk("superpage", 32'h0123_4567, 32'h0001_0000, 1, 0, 0, 0, 0);

        mem.delete();
        do_walk("inv_l1", 32'h0123_4567, 32'h0001_0000, 2, 0, 0, 0, 0);

        mem.delete();
        mem[32'h0003_0004] = 32'h0005_0001;
        mem[32'h0005_0004] = 32'h1000_0000;
        do_walk("inv_l2", 32'h0040_1000, 32'h0003_0000, 1, 2, 0, 0, 0);

        mem.delete();
        mem[32'h0001_0010] = 32'h4040_0003;
        do_walk("timeout", 32'h0123_4567, 32'h0001_0000, 1000, 0, 0, 1, 0);
        do_walk("ack_at_limit", 32'h0123_4567, 32'h0001_0000, TIMEOUT - 1, 0, 0, 0, 0);

        mem.delete();
        mem[32'h0003_0004] = 32'h0005_0001;
        mem[32'h0005_0004] = 32'h1234_5001;
        do_walk("timeout_l2", 32'h0040_1000, 32'h0003_0000, 0, 1000, 0, 1, 0);

        mem.delete();
        mem[32'h0008_0800] = 32'h00C0_0003;
        do_walk("held_req", 32'h8000_0000, 32'h0008_0000, 1, 0, 1, 0, 0);

        mem.delete();
        mem[32'h0001_0FFC] = 32'h0002_0001;
        mem[32'h0002_0FFC] = 32'h1000_0001;
        do_walk("reset_mid", 32'hFFFF_F00A, 32'h0001_0000, 1, 1000, 0, 0, 1);
        do_walk("after_reset", 32'hFFFF_F00A, 32'h0001_0000, 3, 3, 0, 0, 0);

        for (int i = 0; i < 40; i++) begin
            mem.delete();
            kind = $urandom_range(0, 3);
            va   = $urandom;
            pt   = $urandom;
            l1a  = (pt & 32'hFFFF_F000) + ((va >> 22) << 2);
            junk = $urandom & 32'h0000_0FFC;
            t    = $urandom & 32'hFFFF_F000;
            l2a  = t + (((va >> 12) & 32'h3FF) << 2);
            case (kind)
                0: mem[l1a] = ($urandom & 32'hFFFF_F000) | junk | 32'h3;
                1: begin
                    mem[l1a] = t | junk | 32'h1;
                    mem[l2a] = ($urandom & 32'hFFFF_F000) | junk | ($urandom & 32'h2) | 32'h1;
                end
                2: mem[l1a] = $urandom & 32'hFFFF_FFFE;
                default: begin
                    mem[l1a] = t | junk | 32'h1;
                    mem[l2a] = $urandom & 32'hFFFF_FFFE;
                end
            endcase
            do_walk($sformatf("rand%0d", i), va, pt, $urandom_range(0, 4), $urandom_range(0, 4), 0, 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

endmodule
